// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, async imem address, IF/ID register; 1-cycle fetch latency.
// Stall holds PC and IF/ID; redirect flushes the slot and overrides stall/halt.
module fetch_stage #(
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'h7
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_next,
  output logic                  halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  is_halt;

  assign pc_inc    = pc + 1'b1;
  assign is_halt   = (imem_instr[DATA_WIDTH-1 -: 4] == HALT_OPCODE);
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
    end else if (redirect_valid) begin
      // wrong-path slot is dropped; if_pc/if_pc_next are don't-care while invalid
      state    <= RUN;
      pc       <= redirect_target;
      if_valid <= 1'b0;
      if_instr <= '0;
    end else if (stall) begin
      state <= state;
    end else if (state == HALT) begin
      if_valid <= 1'b0;
      if_instr <= '0;
    end else begin
      if_valid   <= 1'b1;
      if_instr   <= imem_instr;
      if_pc      <= pc;
      if_pc_next <= pc_inc;
      if (is_halt) begin
        state <= HALT;
      end else begin
        pc <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: an 8-bit-PC instance for flow control and
// a 4-bit-PC instance (RESET_PC=3) for wrap-around and mid-run reset.
module tb_fetch_stage;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, stall_a = 1'b0, redir_a = 1'b0;
  logic [7:0]  target_a = '0;
  logic [7:0]  imem_addr_a, if_pc_a, if_pc_next_a;
  logic [15:0] imem_instr_a, if_instr_a;
  logic        if_valid_a, halted_a;

  logic        rst_b = 1'b1;
  logic [3:0]  imem_addr_b, if_pc_b, if_pc_next_b;
  logic [15:0] imem_instr_b, if_instr_b;
  logic        if_valid_b, halted_b;

  logic [15:0] mem8 [256];
  logic [15:0] mem4 [16];

  assign imem_instr_a = mem8[imem_addr_a];
  assign imem_instr_b = mem4[imem_addr_b];

  fetch_stage #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RESET_PC(8'h00), .HALT_OPCODE(4'h7)) dut_a (
    .clk(clk), .rst(rst_a), .imem_addr(imem_addr_a), .imem_instr(imem_instr_a),
    .stall(stall_a), .redirect_valid(redir_a), .redirect_target(target_a),
    .if_valid(if_valid_a), .if_instr(if_instr_a), .if_pc(if_pc_a),
    .if_pc_next(if_pc_next_a), .halted(halted_a)
  );

  fetch_stage #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RESET_PC(4'h3), .HALT_OPCODE(4'h7)) dut_b (
    .clk(clk), .rst(rst_b), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_target(4'h0),
    .if_valid(if_valid_b), .if_instr(if_instr_b), .if_pc(if_pc_b),
    .if_pc_next(if_pc_next_b), .halted(halted_b)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int pc);
    exp_t e;
    e.pc    = 8'(pc);
    e.instr = mem8[pc];
    sb_q.push_back(e);
  endtask

  // One clock; afterwards, any newly latched valid instruction of dut_a is
  // checked against the head of the scoreboard.
  task automatic step();
    logic fresh;
    exp_t e;
    fresh = !stall_a && !rst_a;
    @(posedge clk);
    #1;
    if (fresh && if_valid_a) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", if_valid_a, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_if_pc", if_pc_a, e.pc);
        chk("sb_if_instr", if_instr_a, e.instr);
        chk("sb_if_pc_next", if_pc_next_a, 8'(e.pc + 8'd1));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem8[i] = {4'h3, 4'h0, 8'(i)};
    mem8[0]  = 16'h2000;
    mem8[1]  = 16'h2101;
    mem8[2]  = 16'h2200;
    mem8[15] = 16'h7000;
    for (int i = 0; i < 16; i++) mem4[i] = {4'h1, 8'h00, 4'(i)};

    // 1: reset then free-run
    step();
    chk("rst_if_valid", if_valid_a, 1'b0);
    chk("rst_if_instr", if_instr_a, 16'h0);
    chk("rst_if_pc", if_pc_a, 8'h0);
    chk("rst_if_pc_next", if_pc_next_a, 8'h0);
    chk("rst_halted", halted_a, 1'b0);
    chk("rst_imem_addr", imem_addr_a, 8'h0);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(i);
    step();
    chk("run_imem_addr1", imem_addr_a, 8'h1);
    step();
    step();
    chk("run_imem_addr3", imem_addr_a, 8'h3);

    // 2: two-cycle stall with if_pc=3
    push_exp(3);
    step();
    stall_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_if_pc", if_pc_a, 8'h3);
      chk("stall_if_valid", if_valid_a, 1'b1);
      chk("stall_if_instr", if_instr_a, mem8[3]);
      chk("stall_imem_addr", imem_addr_a, 8'h4);
    end
    stall_a = 1'b0;
    for (int i = 4; i < 14; i++) push_exp(i);
    for (int i = 4; i < 14; i++) step();
    chk("pre_redir_addr", imem_addr_a, 8'h0E);

    // 3: redirect to 0x08 from pc=0x0E
    redir_a = 1'b1; target_a = 8'h08;
    step();
    chk("redir_if_valid", if_valid_a, 1'b0);
    chk("redir_if_instr", if_instr_a, 16'h0);
    chk("redir_imem_addr", imem_addr_a, 8'h08);
    redir_a = 1'b0;
    push_exp(8);
    step();

    // 4: redirect together with stall
    redir_a = 1'b1; stall_a = 1'b1; target_a = 8'h0C;
    step();
    chk("redir_stall_addr", imem_addr_a, 8'h0C);
    chk("redir_stall_valid", if_valid_a, 1'b0);
    redir_a = 1'b0; stall_a = 1'b0;

    // 5: HALT at 0x0F
    for (int i = 12; i < 16; i++) push_exp(i);
    for (int i = 12; i < 16; i++) step();
    chk("halt_halted", halted_a, 1'b1);
    chk("halt_addr", imem_addr_a, 8'h0F);
    chk("halt_if_valid_on_halt", if_valid_a, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halted_if_valid", if_valid_a, 1'b0);
      chk("halted_if_instr", if_instr_a, 16'h0);
      chk("halted_stays", halted_a, 1'b1);
      chk("halted_addr", imem_addr_a, 8'h0F);
    end
    redir_a = 1'b1; target_a = 8'h00;
    step();
    chk("unhalt_halted", halted_a, 1'b0);
    chk("unhalt_addr", imem_addr_a, 8'h00);
    redir_a = 1'b0;
    push_exp(0);
    push_exp(1);
    step();
    step();
    chk("sb_drained", sb_q.size(), 0);
    rst_a = 1'b1;

    // 6: 4-bit PC wrap and mid-run reset (RESET_PC = 3)
    step();
    chk("b_rst_addr", imem_addr_b, 4'h3);
    chk("b_rst_valid", if_valid_b, 1'b0);
    rst_b = 1'b0;
    for (int i = 3; i < 16; i++) step();
    chk("b_wrap_if_pc", if_pc_b, 4'hF);
    chk("b_wrap_if_pc_next", if_pc_next_b, 4'h0);
    chk("b_wrap_if_instr", if_instr_b, 16'h100F);
    chk("b_wrap_addr", imem_addr_b, 4'h0);
    step();
    chk("b_after_wrap_if_pc", if_pc_b, 4'h0);
    chk("b_after_wrap_instr", if_instr_b, 16'h1000);
    chk("b_after_wrap_addr", imem_addr_b, 4'h1);
    step();
    rst_b = 1'b1;
    step();
    chk("b_midrst_addr", imem_addr_b, 4'h3);
    chk("b_midrst_valid", if_valid_b, 1'b0);
    chk("b_midrst_if_pc", if_pc_b, 4'h0);
    chk("b_halted", halted_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
